rv_alu_arbiter: RTL

//  Shares one combinational RV ALU between two requesters: port 0 (pipeline EX stage) and port 1
//  (auxiliary unit, e.g. CSR/debug address calc). Arbitrates per cycle and drives the shared ALU's
//  op/operand inputs. Captures alu_out into a one-entry response slot per port with valid/ready.

---
 rtl/rv_alu_pkg.sv | 30 +++
 rtl/rv_alu_rsp_slot.sv | 27 ++
 rtl/rv_alu_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/rv_alu_pkg.sv
// Shared constants for the RV ALU arbiter slice: bus widths, ALU op-codes
// ({funct7[5], funct3} style) and the grant-priority helper.
package rv_alu_pkg;

    localparam int BUS_W     = 32;
    localparam int OP_W      = 4;
    localparam int NUM_PORTS = 2;

    localparam logic [OP_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SLL    = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLT    = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SLTU   = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL    = 4'b0101;
    localparam logic [OP_W-1:0] ALU_OR     = 4'b0110;
    localparam logic [OP_W-1:0] ALU_AND    = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SUB    = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SRA    = 4'b1101;
    localparam logic [OP_W-1:0] ALU_PCPLUS = 4'b1111;

    // Starved port 1 beats port 0; otherwise port 0 has fixed priority.
    function automatic logic [1:0] arb_grant(input logic elig0, input logic elig1,
                                             input logic force1);
        if (force1) return 2'b10;
        if (elig0)  return 2'b01;
        if (elig1)  return 2'b10;
        return 2'b00;
    endfunction

endpackage

// File: rtl/rv_alu_rsp_slot.sv
// One-entry response register with valid/ready: loads on grant, clears on
// drain, and a same-cycle drain+refill keeps valid high with the new data.
module rv_alu_rsp_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rv_alu_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and an auxiliary
// requester (port 1); results land in a one-entry slot per port the next cycle.
module rv_alu_arbiter #(
    parameter int BUS_W    = rv_alu_pkg::BUS_W,
    parameter int OP_W     = rv_alu_pkg::OP_W,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [BUS_W-1:0] req0_a,
    input  logic [BUS_W-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [BUS_W-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [BUS_W-1:0] req1_a,
    input  logic [BUS_W-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [BUS_W-1:0] rsp1_data,
    output logic [OP_W-1:0]  alu_op,
    output logic [BUS_W-1:0] alu_src_a,
    output logic [BUS_W-1:0] alu_src_b,
    input  logic [BUS_W-1:0] alu_out,
    output logic [1:0]       grant
);
    import rv_alu_pkg::arb_grant;

    localparam int NP    = 2;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [NP-1:0]            req_valid, rsp_ready, rsp_valid, elig, grant_c;
    logic [NP-1:0][OP_W-1:0]  req_op;
    logic [NP-1:0][BUS_W-1:0] req_a, req_b, rsp_data;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     force1;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_op    = {req1_op, req0_op};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};

    // A full slot only blocks its own port, never the other one.
    assign elig   = req_valid & (~rsp_valid | rsp_ready);
    assign force1 = elig[1] && (wait_cnt == CNT_W'(MAX_WAIT));

    always_comb begin
        grant_c = 2'b00;
        if (!rst) grant_c = arb_grant(elig[0], elig[1], force1);
    end

    assign grant      = grant_c;
    assign req0_ready = grant_c[0];
    assign req1_ready = grant_c[1];

    always_comb begin
        alu_op    = '0;
        alu_src_a = '0;
        alu_src_b = '0;
        if (grant_c[1]) begin
            alu_op    = req_op[1];
            alu_src_a = req_a[1];
            alu_src_b = req_b[1];
        end else if (grant_c[0]) begin
            alu_op    = req_op[0];
            alu_src_a = req_a[0];
            alu_src_b = req_b[0];
        end
    end

    // Counts lost cycles even while port 1's own slot is full, so it is
    // force-granted as soon as that slot drains.
    always_ff @(posedge clk) begin
        if (rst || !req1_valid || grant_c[1]) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_slot
        rv_alu_rsp_slot #(.W(BUS_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (grant_c[p]),
            .load_data (alu_out),
            .ready     (rsp_ready[p]),
            .valid     (rsp_valid[p]),
            .data      (rsp_data[p])
        );
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];

endmodule
